// File: rtl/seq_det_pkg.sv
// Shared encodings for the 1011 detector engine and the round-robin scheduler controller.
package seq_det_pkg;

    localparam int ENG_W = 3;
    localparam int CTL_W = 2;

    typedef enum logic [ENG_W-1:0] {
        ENG_S0 = 3'd0,
        ENG_S1 = 3'd1,
        ENG_S2 = 3'd2,
        ENG_S3 = 3'd3,
        ENG_S4 = 3'd4
    } eng_state_t;

    typedef enum logic [CTL_W-1:0] {
        CTL_IDLE  = 2'd0,
        CTL_SHIFT = 2'd1,
        CTL_FLUSH = 2'd2,
        CTL_RESP  = 2'd3
    } ctl_state_t;

    // Non-overlapping transitions: after a hit the search restarts from scratch.
    function automatic eng_state_t eng_next(input eng_state_t s, input logic x);
        eng_state_t n;
        case (s)
            ENG_S0:  n = x ? ENG_S1 : ENG_S0;
            ENG_S1:  n = x ? ENG_S1 : ENG_S2;
            ENG_S2:  n = x ? ENG_S3 : ENG_S0;
            ENG_S3:  n = x ? ENG_S4 : ENG_S2;
            ENG_S4:  n = x ? ENG_S1 : ENG_S0;
            default: n = ENG_S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seq1011_engine.sv
// Serial Moore "1011" detector with advance enable and synchronous clear.
module seq1011_engine
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic x,
    output logic y
);

    eng_state_t r_state;
    eng_state_t w_state_next;

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = ENG_S0;
        end else if (en) begin
            w_state_next = eng_next(r_state, x);
        end else if (!(r_state inside {ENG_S0, ENG_S1, ENG_S2, ENG_S3, ENG_S4})) begin
            w_state_next = ENG_S0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ENG_S0;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign y = (r_state == ENG_S4);

endmodule

// File: rtl/seq1011_rr_scheduler.sv
// Round-robin scheduler sharing one serial 1011 detector among N_REQ byte requesters.
// Handshake: a word moves when req_ready[i] pulses; a response moves when rsp_valid && rsp_ready.
module seq1011_rr_scheduler
    import seq_det_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 4,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int BC_W   = $clog2(DATA_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [CNT_W-1:0]        rsp_count,
    input  logic                    rsp_ready
);

    ctl_state_t        r_state;
    ctl_state_t        w_state_next;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_shift;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]  r_match_cnt;
    logic [ID_W-1:0]   r_rsp_id;
    logic [CNT_W-1:0]  r_rsp_count;

    logic              w_grant_found;
    logic [ID_W-1:0]   w_grant_idx;
    logic [ID_W-1:0]   w_cand;
    logic              w_grant;
    logic [N_REQ-1:0]  w_req_ready;
    logic              w_eng_en;
    logic              w_eng_clr;
    logic              w_eng_x;
    logic              w_eng_y;
    logic              w_last_bit;
    logic              w_sample;
    logic [CNT_W-1:0]  w_cnt_next;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = ID_W'((int'(r_ptr) + i) % N_REQ);
            if (!w_grant_found && req_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // Gated by reset so no word is claimed while the block is held in reset.
    assign w_grant = (r_state == CTL_IDLE) && w_grant_found && !reset;

    always_comb begin
        w_req_ready = '0;
        if (w_grant) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_last_bit = (r_bit_cnt == BC_W'(DATA_W - 1));

    always_comb begin
        w_state_next = r_state;
        w_eng_en     = 1'b0;
        w_eng_clr    = 1'b0;
        case (r_state)
            CTL_IDLE: begin
                w_eng_clr = w_grant;
                if (w_grant) begin
                    w_state_next = CTL_SHIFT;
                end
            end
            CTL_SHIFT: begin
                w_eng_en = 1'b1;
                if (w_last_bit) begin
                    w_state_next = CTL_FLUSH;
                end
            end
            CTL_FLUSH: begin
                w_state_next = CTL_RESP;
            end
            CTL_RESP: begin
                if (rsp_ready) begin
                    w_state_next = CTL_IDLE;
                end
            end
            default: begin
                w_state_next = CTL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CTL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Engine output reflects bits already shifted, so shift cycle 0 has nothing to report.
    assign w_sample   = ((r_state == CTL_SHIFT) && (r_bit_cnt != '0)) || (r_state == CTL_FLUSH);
    assign w_cnt_next = (w_sample && w_eng_y && (r_match_cnt != {CNT_W{1'b1}}))
                        ? r_match_cnt + CNT_W'(1) : r_match_cnt;
    assign w_eng_x    = r_shift[DATA_W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_match_cnt <= '0;
            r_rsp_id    <= '0;
            r_rsp_count <= '0;
        end else begin
            if (w_grant) begin
                r_shift     <= req_data[int'(w_grant_idx)*DATA_W +: DATA_W];
                r_id        <= w_grant_idx;
                r_bit_cnt   <= '0;
                r_match_cnt <= '0;
                r_ptr       <= (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
            end
            if (r_state == CTL_SHIFT) begin
                r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
            if (w_sample) begin
                r_match_cnt <= w_cnt_next;
            end
            if (r_state == CTL_FLUSH) begin
                r_rsp_id    <= r_id;
                r_rsp_count <= w_cnt_next;
            end
        end
    end

    seq1011_engine u_engine (
        .clk   (clk),
        .reset (reset),
        .en    (w_eng_en),
        .clr   (w_eng_clr),
        .x     (w_eng_x),
        .y     (w_eng_y)
    );

    assign req_ready = w_req_ready;
    assign rsp_valid = (r_state == CTL_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_count = r_rsp_count;

endmodule

// File: tb/tb_seq1011_rr_scheduler.sv
// Directed bench for seq1011_rr_scheduler: a default instance plus a CNT_W=1 instance for saturation.
module tb_seq1011_rr_scheduler;

    logic        clk;
    logic        reset;

    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_count;
    logic        rsp_ready;

    logic [3:0]  req_valid1;
    logic [31:0] req_data1;
    logic [3:0]  req_ready1;
    logic        rsp_valid1;
    logic [1:0]  rsp_id1;
    logic [0:0]  rsp_count1;
    logic        rsp_ready1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_cnt [4];

    seq1011_rr_scheduler #(.N_REQ(4), .DATA_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_ready (rsp_ready)
    );

    seq1011_rr_scheduler #(.N_REQ(4), .DATA_W(8), .CNT_W(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid1),
        .req_data  (req_data1),
        .req_ready (req_ready1),
        .rsp_valid (rsp_valid1),
        .rsp_id    (rsp_id1),
        .rsp_count (rsp_count1),
        .rsp_ready (rsp_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    initial begin
        reset      = 1'b1;
        req_valid  = 4'h0;
        req_data   = 32'h0;
        rsp_ready  = 1'b1;
        req_valid1 = 4'h0;
        req_data1  = 32'h0;
        rsp_ready1 = 1'b1;
        exp_cnt[0] = 32'd2;
        exp_cnt[1] = 32'd0;
        exp_cnt[2] = 32'd1;
        exp_cnt[3] = 32'd1;

        // Reset state, including a request held during reset
        @(negedge clk);
        req_valid = 4'h1;
        #1;
        check("rst_req_ready", req_ready, 32'h0);
        check("rst_rsp_valid", rsp_valid, 32'h0);
        check("rst_rsp_id", rsp_id, 32'h0);
        check("rst_rsp_count", rsp_count, 32'h0);
        check("rst_rsp_valid1", rsp_valid1, 32'h0);
        req_valid = 4'h0;

        // 1: single req0 word 1011_1011
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'h1;
        req_data  = 32'h0000_00BB;
        #1;
        check("t1_grant", req_ready, 32'h1);
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        check("t1_ready_pulse", req_ready, 32'h0);
        repeat (8) @(negedge clk);
        #1;
        check("t1_valid_g9", rsp_valid, 32'h0);
        @(negedge clk);
        #1;
        check("t1_valid_g10", rsp_valid, 32'h1);
        check("t1_id", rsp_id, 32'h0);
        check("t1_count", rsp_count, 32'h2);
        @(negedge clk);
        #1;
        check("t1_valid_done", rsp_valid, 32'h0);

        // 2: non-overlap 1011_0110 on req3 (pointer=1 wraps forward to 3)
        req_valid = 4'h8;
        req_data  = 32'hB600_0000;
        #1;
        check("t2_grant", req_ready, 32'h8);
        @(negedge clk);
        req_valid = 4'h0;
        repeat (9) @(negedge clk);
        #1;
        check("t2_valid", rsp_valid, 32'h1);
        check("t2_id", rsp_id, 32'h3);
        check("t2_count", rsp_count, 32'h1);

        // 3: all four valid continuously, back-to-back grants every 11 cycles
        @(negedge clk);
        req_valid = 4'hF;
        req_data  = 32'h0BB0_00BB;
        for (int t = 0; t < 4; t++) begin
            #1;
            check("t3_grant", req_ready, 32'h1 << t);
            repeat (5) @(negedge clk);
            #1;
            check("t3_busy_ready", req_ready, 32'h0);
            repeat (5) @(negedge clk);
            #1;
            check("t3_valid", rsp_valid, 32'h1);
            check("t3_id", rsp_id, 32'(t));
            check("t3_count", rsp_count, exp_cnt[t]);
            @(negedge clk);
        end

        // 4: backpressure on the fifth word (req0 again)
        #1;
        check("t4_grant", req_ready, 32'h1);
        rsp_ready = 1'b0;
        repeat (10) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t4_hold_valid", rsp_valid, 32'h1);
            check("t4_hold_id", rsp_id, 32'h0);
            check("t4_hold_count", rsp_count, 32'h2);
            check("t4_hold_ready", req_ready, 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_valid_accept", rsp_valid, 32'h1);
        @(negedge clk);
        #1;
        check("t4_next_grant", req_ready, 32'h2);

        // 5: reset during shift bit k=3 of the req1 word
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", rsp_valid, 32'h0);
        check("t5_rst_id", rsp_id, 32'h0);
        check("t5_rst_count", rsp_count, 32'h0);
        check("t5_rst_ready", req_ready, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_regrant", req_ready, 32'h1);
        repeat (6) @(negedge clk);
        #1;
        check("t5_no_stale_rsp", rsp_valid, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("t5_valid_g9", rsp_valid, 32'h0);
        @(negedge clk);
        #1;
        check("t5_valid", rsp_valid, 32'h1);
        check("t5_id", rsp_id, 32'h0);
        check("t5_count", rsp_count, 32'h2);
        req_valid = 4'h0;
        @(negedge clk);
        #1;
        check("t5_idle_valid", rsp_valid, 32'h0);
        check("t5_idle_ready", req_ready, 32'h0);

        // 6: CNT_W=1 saturation and pointer wrap on the second instance
        req_valid1 = 4'h2;
        req_data1  = 32'h0000_BB00;
        #1;
        check("t6_grant", req_ready1, 32'h2);
        repeat (10) @(negedge clk);
        #1;
        check("t6_valid", rsp_valid1, 32'h1);
        check("t6_id", rsp_id1, 32'h1);
        check("t6_count_sat", rsp_count1, 32'h1);
        @(negedge clk);
        #1;
        check("t6_wrap_grant", req_ready1, 32'h2);
        @(negedge clk);
        req_valid1 = 4'h0;
        repeat (9) @(negedge clk);
        #1;
        check("t6_wrap_valid", rsp_valid1, 32'h1);
        check("t6_wrap_id", rsp_id1, 32'h1);
        check("t6_wrap_count", rsp_count1, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
